// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
// Memory-side responder for the IF-stage fetch port. Instructions are served
// combinationally from a one-doubleword buffer. On a miss the buffer is
// refilled from a 64-bit backing memory using a req/gnt handshake followed by
// rvalid, with at most one request outstanding.
//
// Optional feature macro: IFR_ALIGN_CHECK_EN
//   When defined, a fetch whose address has either of its two low bits set
//   raises fault in the same cycle. No instruction is returned and no refill
//   is started for that fetch.
//   When undefined, the two low address bits are ignored and fault is tied to 0.
//
// State table (refill FSM)
//   state  | meaning
//   IDLE   | no refill in flight; a miss latches the line address
//   REQ    | mem_req/mem_addr held stable until mem_gnt
//   WAIT   | request accepted; waiting for mem_rvalid to fill or discard
module imem_fetch_responder #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_ena_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    input  logic                inv_i,
    output logic [INST_W-1:0]   inst_o,
    output logic                inst_valid_o,
    output logic                fetch_stall_o,
    output logic                fault_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [2*INST_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int TAG_W = ADDR_W - 3;

    state_t              state_q;
    logic                buf_valid_q;
    logic [TAG_W-1:0]    buf_tag_q;
    logic [2*INST_W-1:0] buf_data_q;
    logic [TAG_W-1:0]    req_tag_q;
    logic                kill_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;

    logic [TAG_W-1:0]    fetch_tag_w;
    logic                misalign_w;
    logic                hit_w;
    logic                start_w;

    assign fetch_tag_w = inst_addr_i[ADDR_W-1:3];

`ifdef IFR_ALIGN_CHECK_EN
    assign misalign_w = inst_ena_i & (inst_addr_i[1:0] != 2'b00);
`else
    // The low two address bits carry no meaning without the alignment check.
    logic unused_addr_lsb_w;
    assign unused_addr_lsb_w = ^inst_addr_i[1:0];
    assign misalign_w        = 1'b0;
`endif

    // Hit detection and same-cycle fetch-port outputs. All outputs are forced
    // to their idle values while reset is held, whatever the fetch inputs are.
    always_comb begin
        hit_w = ~rst & inst_ena_i & buf_valid_q & (fetch_tag_w == buf_tag_q)
                & ~inv_i & ~misalign_w;
        start_w = inst_ena_i & ~hit_w & ~inv_i & ~misalign_w;
        inst_o = '0;
        if (hit_w) begin
            inst_o = inst_addr_i[2] ? buf_data_q[2*INST_W-1:INST_W]
                                    : buf_data_q[INST_W-1:0];
        end
        inst_valid_o  = hit_w;
        fetch_stall_o = ~rst & inst_ena_i & ~hit_w & ~misalign_w;
        fault_o       = ~rst & misalign_w;
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

    // Refill FSM, fetch buffer and the kill flag that discards a refill
    // invalidated while it was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            req_tag_q   <= '0;
            kill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            if (inv_i) begin
                buf_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_w) begin
                        state_q    <= S_REQ;
                        req_tag_q  <= fetch_tag_w;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {fetch_tag_w, 3'b000};
                    end
                end
                S_REQ: begin
                    // The request is never withdrawn; inv only marks it dead.
                    if (inv_i) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        state_q   <= S_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= S_IDLE;
                        kill_q  <= 1'b0;
                        if (~kill_q & ~inv_i) begin
                            buf_data_q  <= mem_rdata_i;
                            buf_tag_q   <= req_tag_q;
                            buf_valid_q <= 1'b1;
                        end
                    end else if (inv_i) begin
                        kill_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder.
module tb_imem_fetch_responder;

    logic        clk;
    logic        rst;
    logic        inst_ena_i;
    logic [63:0] inst_addr_i;
    logic        inv_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_stall_o;
    logic        fault_o;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    integer checks;
    integer errors;

    localparam logic [63:0] D0   = 64'h00500093_00000013;
    localparam logic [63:0] D8   = 64'h11111111_22222222;
    localparam logic [63:0] D100 = 64'haaaa0100_bbbb0100;
    localparam logic [63:0] D200 = 64'hcccc0200_dddd0200;
    localparam logic [63:0] DX   = 64'hdeaddead_deaddead;
    localparam logic [63:0] D40  = 64'h40404040_04040404;
    localparam logic [63:0] D80  = 64'h80808080_08080808;

    imem_fetch_responder #(.ADDR_W(64), .INST_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_ena_i    (inst_ena_i),
        .inst_addr_i   (inst_addr_i),
        .inv_i         (inv_i),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .fetch_stall_o (fetch_stall_o),
        .fault_o       (fault_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted refill: grant now, data the next cycle, back in IDLE after.
    task automatic serve(input logic [63:0] data, input logic inv_with_data);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        inv_i        = inv_with_data;
        tick();
        mem_rvalid_i = 1'b0;
        inv_i        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ena_i = 1'b0; inst_addr_i = '0; inv_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        tick(); tick();
        checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem: got req=%0b addr=%h want req=0 addr=0", mem_req_o, mem_addr_o);
        end
        checks++;
        if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || fetch_stall_o !== 1'b0 || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: got valid=%0b inst=%h stall=%0b fault=%0b want 0 0 0 0",
                     inst_valid_o, inst_o, fetch_stall_o, fault_o);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_idle_no_request();
        inst_ena_i = 1'b0; inst_addr_i = 64'h998;
        #1;
        checks++;
        if (fetch_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall: got %0b want 0", fetch_stall_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %0b want 0", mem_req_o);
        end
    endtask

    task automatic test_cold_fetch();
        inst_ena_i = 1'b1; inst_addr_i = 64'h0;
        #1;
        checks++;
        if (fetch_stall_o !== 1'b1 || inst_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL cold_c0: got stall=%0b valid=%0b req=%0b want 1 0 0", fetch_stall_o, inst_valid_o, mem_req_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h0 || fetch_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL cold_c1: got req=%0b addr=%h stall=%0b want 1 0 1", mem_req_o, mem_addr_o, fetch_stall_o);
        end
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = D0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || fetch_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL cold_c2: got req=%0b stall=%0b want 0 1", mem_req_o, fetch_stall_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        checks++;
        if (inst_o !== 32'h00000013 || inst_valid_o !== 1'b1 || fetch_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL cold_c3: got inst=%h valid=%0b stall=%0b want 00000013 1 0", inst_o, inst_valid_o, fetch_stall_o);
        end
    endtask

    task automatic test_same_dw_hit();
        inst_addr_i = 64'h4;
        #1;
        checks++;
        if (inst_o !== 32'h00500093 || inst_valid_o !== 1'b1 || fetch_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_hi: got inst=%h valid=%0b stall=%0b want 00500093 1 0", inst_o, inst_valid_o, fetch_stall_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_noreq: got %0b want 0", mem_req_o);
        end
        inst_addr_i = 64'h8;
        #1;
        checks++;
        if (fetch_stall_o !== 1'b1 || inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin
            errors++;
            $display("FAIL miss8_stall: got stall=%0b valid=%0b inst=%h want 1 0 0", fetch_stall_o, inst_valid_o, inst_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8) begin
            errors++;
            $display("FAIL miss8_req: got req=%0b addr=%h want 1 8", mem_req_o, mem_addr_o);
        end
        serve(D8, 1'b0);
        checks++;
        if (inst_o !== 32'h22222222 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL fill8_lo: got inst=%h valid=%0b want 22222222 1", inst_o, inst_valid_o);
        end
        inst_addr_i = 64'hc;
        #1;
        checks++;
        if (inst_o !== 32'h11111111 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL fill8_hi: got inst=%h valid=%0b want 11111111 1", inst_o, inst_valid_o);
        end
    endtask

    task automatic test_backpressure();
        inst_addr_i = 64'h100;
        tick();
        inst_addr_i = 64'h200;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h100) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got req=%0b addr=%h want 1 100", i, mem_req_o, mem_addr_o);
            end
            tick();
        end
        serve(D100, 1'b0);
        checks++;
        if (fetch_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_new_miss: got stall=%0b req=%0b want 1 0", fetch_stall_o, mem_req_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h200) begin
            errors++;
            $display("FAIL bp_req200: got req=%0b addr=%h want 1 200", mem_req_o, mem_addr_o);
        end
        inst_addr_i = 64'h100;
        #1;
        checks++;
        if (inst_o !== 32'hbbbb0100 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill100: got inst=%h valid=%0b want bbbb0100 1", inst_o, inst_valid_o);
        end
        inst_addr_i = 64'h204;
        serve(D200, 1'b0);
        checks++;
        if (inst_o !== 32'hcccc0200 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill200: got inst=%h valid=%0b want cccc0200 1", inst_o, inst_valid_o);
        end
    endtask

    task automatic test_inv_wait();
        inst_addr_i = 64'h40;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; inv_i = 1'b1;
        tick();
        inv_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = DX;
        tick();
        mem_rvalid_i = 1'b0;
        inst_addr_i = 64'h200;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || fetch_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL invw_old_gone: got valid=%0b stall=%0b want 0 1", inst_valid_o, fetch_stall_o);
        end
        inst_addr_i = 64'h40;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0 || fetch_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL invw_discard: got valid=%0b stall=%0b want 0 1", inst_valid_o, fetch_stall_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h40) begin
            errors++;
            $display("FAIL invw_rereq: got req=%0b addr=%h want 1 40", mem_req_o, mem_addr_o);
        end
        serve(D40, 1'b0);
        checks++;
        if (inst_o !== 32'h04040404 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL invw_refill: got inst=%h valid=%0b want 04040404 1", inst_o, inst_valid_o);
        end
    endtask

    task automatic test_inv_with_rvalid();
        inst_addr_i = 64'h80;
        tick();
        serve(DX, 1'b1);
        checks++;
        if (inst_valid_o !== 1'b0 || fetch_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL invr_discard: got valid=%0b stall=%0b want 0 1", inst_valid_o, fetch_stall_o);
        end
        inst_addr_i = 64'h40;
        #1;
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL invr_old_gone: got valid=%0b want 0", inst_valid_o);
        end
        inst_addr_i = 64'h80;
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h80) begin
            errors++;
            $display("FAIL invr_rereq: got req=%0b addr=%h want 1 80", mem_req_o, mem_addr_o);
        end
        serve(D80, 1'b0);
        checks++;
        if (inst_o !== 32'h08080808 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL invr_refill: got inst=%h valid=%0b want 08080808 1", inst_o, inst_valid_o);
        end
    endtask

    task automatic test_misaligned();
        inst_addr_i = 64'h86;
        #1;
`ifdef IFR_ALIGN_CHECK_EN
        checks++;
        if (fault_o !== 1'b1 || fetch_stall_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin
            errors++;
            $display("FAIL align_fault: got fault=%0b stall=%0b valid=%0b inst=%h want 1 0 0 0",
                     fault_o, fetch_stall_o, inst_valid_o, inst_o);
        end
        inst_addr_i = 64'h306;
        #1;
        tick();
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL align_noreq: got %0b want 0", mem_req_o);
        end
`else
        checks++;
        if (fault_o !== 1'b0 || inst_o !== 32'h80808080 || inst_valid_o !== 1'b1 || fetch_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL noalign_hit: got fault=%0b inst=%h valid=%0b stall=%0b want 0 80808080 1 0",
                     fault_o, inst_o, inst_valid_o, fetch_stall_o);
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL noalign_noreq: got %0b want 0", mem_req_o);
        end
`endif
        inst_ena_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle_no_request();
        test_cold_fetch();
        test_same_dw_hit();
        test_backpressure();
        test_inv_wait();
        test_inv_with_rvalid();
        test_misaligned();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
